// File: rtl/game_pkg.sv
// Shared constants, state encoding and cell addressing for the match-3 board sequencer.
package game_pkg;

  localparam int N         = 8;
  localparam int CELL_W    = 3;
  localparam int MAX_CHAIN = 15;

  localparam logic [2:0] EMPTY = 3'b000;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SWAP         = 3'd1,
    MATCH_REQ    = 3'd2,
    MATCH_WAIT   = 3'd3,
    CLEAR        = 3'd4,
    REFRESH_REQ  = 3'd5,
    REFRESH_WAIT = 3'd6,
    REVERT       = 3'd7
  } state_t;

  // Cell i = 8*row + col lives at bits [3i+2:3i] of the flat board vector.
  function automatic logic [7:0] cell_lsb(input logic [5:0] idx);
    return 8'(idx) * 8'(CELL_W);
  endfunction

endpackage

// File: rtl/cell_popcount.sv
// Combinational count of set bits in a 64-cell match mask.
module cell_popcount (
  input  logic [63:0] mask,
  output logic [6:0]  count
);

  // Sum every mask bit into the 7-bit result.
  always_comb begin
    count = 7'd0;
    for (int i = 0; i < 64; i++) begin
      count = count + 7'(mask[i]);
    end
  end

endmodule

// File: rtl/board_sequencer.sv
// Move sequencer for a match-3 board: swap, match scan, clear, refresh cascade, revert.
module board_sequencer #(
  parameter int N         = game_pkg::N,
  parameter int CELL_W    = game_pkg::CELL_W,
  parameter int MAX_CHAIN = game_pkg::MAX_CHAIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [N*N*CELL_W-1:0] load_board,
  input  logic                  swap_req,
  input  logic [5:0]            swap_a,
  input  logic [5:0]            swap_b,
  output logic                  match_start,
  input  logic                  match_valid,
  input  logic [N*N-1:0]        match_mask,
  output logic                  refresh_start,
  input  logic                  refresh_done,
  input  logic [N*N*CELL_W-1:0] refresh_board,
  output logic [N*N*CELL_W-1:0] board,
  output logic                  busy,
  output logic [15:0]           score,
  output logic [3:0]            chain,
  output logic                  swap_err
);

  import game_pkg::*;

  localparam int BW = N * N * CELL_W;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [BW-1:0]   board_r;
  logic [BW-1:0]   swapped_s;
  logic [BW-1:0]   cleared_s;
  logic [5:0]      idx_a_r;
  logic [5:0]      idx_b_r;
  logic [N*N-1:0]  mask_r;
  logic [15:0]     score_r;
  logic [3:0]      chain_r;
  logic [6:0]      clear_cnt_s;
  logic [16:0]     score_sum_s;

  logic            busy_r;
  logic            match_start_r;
  logic            refresh_start_r;
  logic            swap_err_r;
  logic            busy_nxt_s;
  logic            match_start_nxt_s;
  logic            refresh_start_nxt_s;
  logic            swap_err_nxt_s;

  logic [3:0]      row_a_s;
  logic [3:0]      row_b_s;
  logic [3:0]      col_a_s;
  logic [3:0]      col_b_s;
  logic            adjacent_s;
  logic            swap_accept_s;
  logic            swap_reject_s;

  cell_popcount u_popcount (
    .mask  (mask_r),
    .count (clear_cnt_s)
  );

  // Orthogonal adjacency; the 4-bit compare keeps col 7 and col 0 of the next row apart.
  always_comb begin
    row_a_s = {1'b0, swap_a[5:3]};
    row_b_s = {1'b0, swap_b[5:3]};
    col_a_s = {1'b0, swap_a[2:0]};
    col_b_s = {1'b0, swap_b[2:0]};
    if (row_a_s == row_b_s) begin
      adjacent_s = (col_a_s == col_b_s + 4'd1) || (col_b_s == col_a_s + 4'd1);
    end else if (col_a_s == col_b_s) begin
      adjacent_s = (row_a_s == row_b_s + 4'd1) || (row_b_s == row_a_s + 4'd1);
    end else begin
      adjacent_s = 1'b0;
    end
  end

  // Load wins over a same-cycle swap request; both are only seen in IDLE.
  always_comb begin
    swap_accept_s = (state_r == IDLE) && !load && swap_req && adjacent_s;
    swap_reject_s = (state_r == IDLE) && !load && swap_req && !adjacent_s;
  end

  // Exchange the two latched cells; used for both the move and its undo.
  always_comb begin
    swapped_s = board_r;
    swapped_s[cell_lsb(idx_a_r) +: CELL_W] = board_r[cell_lsb(idx_b_r) +: CELL_W];
    swapped_s[cell_lsb(idx_b_r) +: CELL_W] = board_r[cell_lsb(idx_a_r) +: CELL_W];
  end

  // Empty every cell flagged by the latched match mask.
  always_comb begin
    cleared_s = board_r;
    for (int i = 0; i < N * N; i++) begin
      if (mask_r[i]) begin
        cleared_s[cell_lsb(6'(i)) +: CELL_W] = EMPTY;
      end else begin
        cleared_s[cell_lsb(6'(i)) +: CELL_W] = board_r[cell_lsb(6'(i)) +: CELL_W];
      end
    end
  end

  // Widened score sum so saturation can be detected from the carry.
  always_comb begin
    score_sum_s = {1'b0, score_r} + {10'd0, clear_cnt_s};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (swap_accept_s) begin
          state_nxt_s = SWAP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SWAP:        state_nxt_s = MATCH_REQ;
      MATCH_REQ:   state_nxt_s = MATCH_WAIT;
      MATCH_WAIT: begin
        if (!match_valid) begin
          state_nxt_s = MATCH_WAIT;
        end else if (match_mask != '0) begin
          state_nxt_s = CLEAR;
        end else if (chain_r == 4'd0) begin
          state_nxt_s = REVERT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR:       state_nxt_s = REFRESH_REQ;
      REFRESH_REQ: state_nxt_s = REFRESH_WAIT;
      REFRESH_WAIT: begin
        if (!refresh_done) begin
          state_nxt_s = REFRESH_WAIT;
        end else if (chain_r < 4'(MAX_CHAIN)) begin
          state_nxt_s = MATCH_REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REVERT:      state_nxt_s = IDLE;
      default:     state_nxt_s = IDLE;
    endcase
  end

  // Output decode, registered below so every pulse lines up with its state.
  always_comb begin
    busy_nxt_s          = (state_nxt_s != IDLE);
    match_start_nxt_s   = (state_nxt_s == MATCH_REQ);
    refresh_start_nxt_s = (state_nxt_s == REFRESH_REQ);
    swap_err_nxt_s      = swap_reject_s || (state_nxt_s == REVERT);
  end

  // Registered status and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r          <= 1'b0;
      match_start_r   <= 1'b0;
      refresh_start_r <= 1'b0;
      swap_err_r      <= 1'b0;
    end else begin
      busy_r          <= busy_nxt_s;
      match_start_r   <= match_start_nxt_s;
      refresh_start_r <= refresh_start_nxt_s;
      swap_err_r      <= swap_err_nxt_s;
    end
  end

  // Board, score, chain and latched move operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_r <= '0;
      score_r <= 16'd0;
      chain_r <= 4'd0;
      idx_a_r <= 6'd0;
      idx_b_r <= 6'd0;
      mask_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load) begin
            board_r <= load_board;
            score_r <= 16'd0;
            chain_r <= 4'd0;
          end else if (swap_accept_s) begin
            idx_a_r <= swap_a;
            idx_b_r <= swap_b;
            chain_r <= 4'd0;
          end
        end
        SWAP, REVERT: begin
          board_r <= swapped_s;
        end
        MATCH_WAIT: begin
          if (match_valid) begin
            mask_r <= match_mask;
          end
        end
        CLEAR: begin
          board_r <= cleared_s;
          score_r <= score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
          if (chain_r < 4'(MAX_CHAIN)) begin
            chain_r <= chain_r + 4'd1;
          end
        end
        REFRESH_WAIT: begin
          if (refresh_done) begin
            board_r <= refresh_board;
          end
        end
        default: begin
          board_r <= board_r;
        end
      endcase
    end
  end

  assign board         = board_r;
  assign score         = score_r;
  assign chain         = chain_r;
  assign busy          = busy_r;
  assign match_start   = match_start_r;
  assign refresh_start = refresh_start_r;
  assign swap_err      = swap_err_r;

endmodule

// File: tb/tb_board_sequencer.sv
// Randomized bench for board_sequencer with a cell-array reference model of each move.
`timescale 1ns/1ps
module tb_board_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [191:0] load_board = '0;
  logic         swap_req = 1'b0;
  logic [5:0]   swap_a = 6'd0;
  logic [5:0]   swap_b = 6'd0;
  logic         match_start;
  logic         match_valid = 1'b0;
  logic [63:0]  match_mask = '0;
  logic         refresh_start;
  logic         refresh_done = 1'b0;
  logic [191:0] refresh_board = '0;
  logic [191:0] board;
  logic         busy;
  logic [15:0]  score;
  logic [3:0]   chain;
  logic         swap_err;

  int vectors = 0;
  int miscompares = 0;
  int match_cnt = 0;
  int refresh_cnt = 0;
  int err_cnt = 0;

  int cells[64];
  int score_m = 0;
  int chain_m = 0;
  logic [63:0] mask_q[$];

  always #5 clk = ~clk;

  board_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .load_board    (load_board),
    .swap_req      (swap_req),
    .swap_a        (swap_a),
    .swap_b        (swap_b),
    .match_start   (match_start),
    .match_valid   (match_valid),
    .match_mask    (match_mask),
    .refresh_start (refresh_start),
    .refresh_done  (refresh_done),
    .refresh_board (refresh_board),
    .board         (board),
    .busy          (busy),
    .score         (score),
    .chain         (chain),
    .swap_err      (swap_err)
  );

  always @(negedge clk) begin
    if (match_start)   match_cnt   <= match_cnt + 1;
    if (refresh_start) refresh_cnt <= refresh_cnt + 1;
    if (swap_err)      err_cnt     <= err_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] model_board();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[i*3 +: 3] = 3'(cells[i]);
    return v;
  endfunction

  function automatic void set_cells(input logic [191:0] b);
    for (int i = 0; i < 64; i++) cells[i] = int'(b[i*3 +: 3]);
  endfunction

  function automatic logic [191:0] rand192();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit adjacent(input int a, input int b);
    int ra, rb, ca, cb, dr, dc;
    ra = a / 8; rb = b / 8; ca = a % 8; cb = b % 8;
    dr = (ra > rb) ? ra - rb : rb - ra;
    dc = (ca > cb) ? ca - cb : cb - ca;
    return (dr == 0 && dc == 1) || (dc == 0 && dr == 1);
  endfunction

  task automatic wait_for(input int which, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((which == 0 && match_start) || (which == 1 && refresh_start) || (which == 2 && !busy)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    chk_eq({tag, "_timeout"}, 192'(0), 192'(1));
  endtask

  task automatic do_load(input logic [191:0] b);
    load = 1'b1; load_board = b;
    @(negedge clk);
    load = 1'b0; #1;
    set_cells(b); score_m = 0; chain_m = 0;
    chk_eq("load_board", board, b);
    chk_eq("load_score", 192'(score), 192'(0));
    chk_eq("load_chain", 192'(chain), 192'(0));
    chk_eq("load_busy", 192'(busy), 192'(0));
  endtask

  // One move: swap request, then answer each scan/refresh from mask_q (empty queue = zero mask).
  task automatic run_move(input int a, input int b);
    int m0, r0, e0, exp_m, exp_r, exp_e, dly, t;
    logic [63:0]  m;
    logic [191:0] nb;
    bit ok;
    m0 = match_cnt; r0 = refresh_cnt; e0 = err_cnt;
    exp_m = 0; exp_r = 0; exp_e = 0;
    swap_a = 6'(a); swap_b = 6'(b); swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    if (!adjacent(a, b)) begin
      exp_e = 1;
      chk_eq("reject_err", 192'(swap_err), 192'(1));
      chk_eq("reject_busy", 192'(busy), 192'(0));
    end else begin
      chain_m = 0;
      t = cells[a]; cells[a] = cells[b]; cells[b] = t;
      ok = 1'b1;
      while (ok) begin
        wait_for(0, "match_start", ok);
        if (!ok) break;
        exp_m++;
        chk_eq("board_at_match", board, model_board());
        m = (mask_q.size() > 0) ? mask_q.pop_front() : 64'd0;
        dly = $urandom_range(1, 4);
        for (int d = 1; d <= dly; d++) begin
          @(negedge clk);
          if (d < dly) begin
            refresh_done = 1'($urandom_range(0, 1)); refresh_board = rand192();
          end else begin
            refresh_done = 1'b0; match_valid = 1'b1; match_mask = m;
          end
        end
        @(negedge clk);
        match_valid = 1'b0; refresh_done = 1'b0;
        if (m == 64'd0) begin
          if (chain_m == 0) begin
            t = cells[a]; cells[a] = cells[b]; cells[b] = t;
            exp_e = 1;
          end
          break;
        end
        for (int i = 0; i < 64; i++) if (m[i]) cells[i] = 0;
        score_m = score_m + $countones(m);
        if (score_m > 65535) score_m = 65535;
        if (chain_m < 15) chain_m++;
        wait_for(1, "refresh_start", ok);
        if (!ok) break;
        exp_r++;
        chk_eq("board_at_refresh", board, model_board());
        nb = rand192();
        dly = $urandom_range(1, 4);
        for (int d = 1; d <= dly; d++) begin
          @(negedge clk);
          if (d < dly) begin
            match_valid = 1'($urandom_range(0, 1)); match_mask = {$urandom, $urandom};
          end else begin
            match_valid = 1'b0; refresh_done = 1'b1; refresh_board = nb;
          end
        end
        @(negedge clk);
        refresh_done = 1'b0; match_valid = 1'b0;
        set_cells(nb);
        if (chain_m >= 15) break;
      end
      wait_for(2, "busy_low", ok);
    end
    @(negedge clk); #1;
    chk_eq("board", board, model_board());
    chk_eq("score", 192'(score), 192'(score_m));
    chk_eq("chain", 192'(chain), 192'(chain_m));
    chk_eq("busy_after", 192'(busy), 192'(0));
    chk_eq("match_pulses", 192'(match_cnt - m0), 192'(exp_m));
    chk_eq("refresh_pulses", 192'(refresh_cnt - r0), 192'(exp_r));
    chk_eq("swap_err_pulses", 192'(err_cnt - e0), 192'(exp_e));
    mask_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [191:0] b;
    int a, bb, r0, m0;
    bit ok;

    // Reset values while rst_n is low; then load on the very first edge after release.
    #1;
    chk_eq("rst_board", board, 192'(0));
    chk_eq("rst_score", 192'(score), 192'(0));
    chk_eq("rst_pulses", 192'({match_start, refresh_start, swap_err, busy}), 192'(0));
    repeat (3) @(negedge clk);
    b = rand192();
    rst_n = 1'b1;
    do_load(b);

    // Single clear then zero mask.
    do_load(rand192());
    mask_q.push_back(64'h7);
    run_move(0, 1);
    chk_eq("single_score", 192'(score), 192'(3));
    chk_eq("single_chain", 192'(chain), 192'(1));

    // Row-wrap indices are not adjacent.
    run_move(7, 8);
    // Vertical swap with no match is undone.
    run_move(0, 8);
    chk_eq("revert_score", 192'(score), 192'(3));

    // Three-deep cascade.
    do_load(rand192());
    mask_q.push_back(64'h7);
    mask_q.push_back(64'hF00);
    mask_q.push_back(64'h1F_0000);
    r0 = refresh_cnt;
    run_move(9, 17);
    chk_eq("cascade_score", 192'(score), 192'(12));
    chk_eq("cascade_chain", 192'(chain), 192'(3));
    chk_eq("cascade_refresh", 192'(refresh_cnt - r0), 192'(3));

    // Random moves, including edge neighbours and non-adjacent pairs.
    for (int k = 0; k < 20; k++) begin
      a = $urandom_range(0, 63);
      case ($urandom_range(0, 4))
        0: bb = a + 1;
        1: bb = a - 1;
        2: bb = a + 8;
        3: bb = a - 8;
        default: bb = $urandom_range(0, 63);
      endcase
      if (bb < 0 || bb > 63) bb = a ^ 1;
      for (int j = $urandom_range(0, 3); j > 0; j--) mask_q.push_back({$urandom, $urandom} | 64'd1);
      run_move(a, bb);
    end

    // Chain limit: a sixteenth mask is never requested.
    for (int j = 0; j < 16; j++) mask_q.push_back({$urandom, $urandom} | 64'h80);
    run_move(20, 28);
    chk_eq("chain_limit", 192'(chain), 192'(15));

    // Reset in the middle of REFRESH_WAIT, then a stray refresh_done.
    swap_a = 6'd9; swap_b = 6'd10; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_for(0, "rst_match_start", ok);
    @(negedge clk);
    match_valid = 1'b1; match_mask = 64'hF0;
    @(negedge clk);
    match_valid = 1'b0;
    wait_for(1, "rst_refresh_start", ok);
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk_eq("midrst_board", board, 192'(0));
    chk_eq("midrst_score", 192'(score), 192'(0));
    chk_eq("midrst_chain", 192'(chain), 192'(0));
    chk_eq("midrst_outs", 192'({match_start, refresh_start, swap_err, busy}), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) cells[i] = 0;
    score_m = 0; chain_m = 0;
    refresh_done = 1'b1; refresh_board = rand192();
    @(negedge clk);
    refresh_done = 1'b0;
    @(negedge clk); #1;
    chk_eq("stray_done_board", board, 192'(0));
    chk_eq("stray_done_busy", 192'({match_start, busy}), 192'(0));

    // Same-cycle load and swap: load wins, no move starts.
    b = rand192();
    m0 = match_cnt;
    swap_a = 6'd0; swap_b = 6'd1; swap_req = 1'b1; load = 1'b1; load_board = b;
    @(negedge clk);
    swap_req = 1'b0; load = 1'b0; #1;
    set_cells(b); score_m = 0; chain_m = 0;
    chk_eq("loadswap_board", board, b);
    chk_eq("loadswap_busy", 192'(busy), 192'(0));
    @(negedge clk); #1;
    chk_eq("loadswap_board2", board, b);
    chk_eq("loadswap_nomatch", 192'(match_cnt - m0), 192'(0));

    // Drive the score to FFFE with full-board clears, then saturate.
    for (int k = 0; k < 68; k++) begin
      repeat (15) mask_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      run_move(0, 1);
    end
    repeat (3) mask_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    mask_q.push_back(64'h3FFF_FFFF_FFFF_FFFF);
    run_move(0, 1);
    chk_eq("score_fffe", 192'(score), 192'(16'hFFFE));
    mask_q.push_back(64'h7);
    run_move(0, 1);
    chk_eq("score_sat", 192'(score), 192'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
